// File: rtl/fifo_sc_wr_arb.sv
// Round-robin, packet-locked write arbiter in front of a single fifo_sc write port.
// One requester owns the FIFO for a whole packet. A stall watchdog takes the grant
// back from a requester that goes silent in the middle of a packet.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | no owner; pick the next valid requester round-robin from ptr
// LOCK    | requester grant_id owns the FIFO until its last beat or a timeout
module fifo_sc_wr_arb #(
    parameter int N   = 4,
    parameter int W   = 16,
    parameter int TMO = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_write,
    output logic [W:0]           fifo_data_in,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 err_tmo
);

    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(TMO + 1);
    localparam logic [CW-1:0] STALL_EXPIRE = CW'(TMO - 1);
    localparam logic [CW-1:0] STALL_SAT    = {CW{1'b1}};
    localparam logic [N-1:0]  ONE_HOT_0    = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [N-1:0]    grant_q,    grant_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  ptr_q,      ptr_d;
    logic [CW-1:0]   stall_q,    stall_d;
    logic            err_tmo_q,  err_tmo_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;

    logic            in_lock;
    logic            g_valid;
    logic            g_last;
    logic [W-1:0]    g_data;
    logic            xfer;
    logic            xfer_last;
    logic            stall_expired;

    // Round-robin pick: first valid requester at or above ptr, wrapping modulo N.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDW'(cand);
            end
        end
    end

    // Lane of the current owner. Only meaningful while in LOCK.
    assign in_lock = (state_q == ST_LOCK);
    assign g_valid = req_valid[grant_id_q];
    assign g_last  = req_last[grant_id_q];
    assign g_data  = req_data[grant_id_q*W +: W];

    // Ready depends only on the grant and fifo_full, never on req_valid.
    assign req_ready    = grant_q & {N{in_lock & ~fifo_full}};
    assign xfer         = in_lock & g_valid & ~fifo_full;
    assign xfer_last    = xfer & g_last;
    assign fifo_write   = xfer;
    // Gated so the data bus reads zero when idle and during reset.
    assign fifo_data_in = in_lock ? {g_last, g_data} : '0;

    // A cycle with valid always clears the counter, so a transfer can never
    // coincide with an expiry.
    assign stall_expired = in_lock & ~g_valid & (stall_q == STALL_EXPIRE);

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign err_tmo  = err_tmo_q;

    // Next-state for the arbiter FSM, grant, round-robin pointer and stall watchdog.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        stall_d    = stall_q;
        err_tmo_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_LOCK;
                    grant_d    = ONE_HOT_0 << pick_idx;
                    grant_id_d = pick_idx;
                    // The pointer moves at grant time so a requester cannot win twice
                    // in a row while another one is waiting.
                    ptr_d      = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;
                    stall_d    = '0;
                end
            end
            ST_LOCK: begin
                if (xfer_last) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    stall_d = '0;
                end else if (stall_expired) begin
                    // Packet is truncated; no synthetic last beat is written.
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    stall_d   = '0;
                    err_tmo_d = 1'b1;
                end else if (g_valid) begin
                    // Back-pressure with valid held does not count as a stall.
                    stall_d = '0;
                end else if (stall_q != STALL_SAT) begin
                    stall_d = stall_q + 1'b1;
                end
            end
        endcase
    end

    // State registers; asynchronous active-low reset forces all outputs to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            stall_q    <= '0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            stall_q    <= stall_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    // Structural invariants of the arbiter.
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(grant_q));
    a_grant_matches_state: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ST_LOCK) == (grant_q != '0));
    a_err_only_in_idle: assert property (@(posedge clk) disable iff (!rst)
        err_tmo_q |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_fifo_sc_wr_arb.sv
module tb_fifo_sc_wr_arb;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_write;
    logic [W:0]     fifo_data_in;
    logic [N-1:0]   grant;
    logic [1:0]     grant_id;
    logic           err_tmo;

    fifo_sc_wr_arb #(.N(N), .W(W), .TMO(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_write   (fifo_write),
        .fifo_data_in (fifo_data_in),
        .grant        (grant),
        .grant_id     (grant_id),
        .err_tmo      (err_tmo)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         n_err = 0;
    bit         src_en = 1'b1;
    bit         sb_en  = 1'b1;
    logic [W:0] srcq[N][$];
    logic [W:0] sbq[$];
    int         gseq[$];
    int         wcyc[$];
    logic [N-1:0] prev_g = '0;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         full;
        logic [W-1:0] d0;
        logic [N-1:0] exp_ready;
        logic         exp_write;
        logic [W:0]   exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present the head beat of each source queue.
    task automatic drive();
        logic [W:0] h;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                h = srcq[i][0];
                req_valid[i]         = 1'b1;
                req_last[i]          = h[W];
                req_data[i*W +: W]   = h[W-1:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_data[i*W +: W]   = '0;
            end
        end
    endtask

    // One clock: monitor at negedge, advance sources after posedge, return at posedge+2.
    task automatic step();
        logic [N-1:0] acc;
        logic [W:0]   e;
        @(negedge clk);
        acc = req_valid & req_ready;
        if (err_tmo) n_err++;
        if (grant != '0 && prev_g == '0) gseq.push_back(int'(grant_id));
        prev_g = grant;
        if (fifo_write && sb_en) begin
            wcyc.push_back(cyc);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_write: got %0h expected no write", fifo_data_in);
            end else begin
                e = sbq.pop_front();
                chk("sb_data", {47'd0, fifo_data_in}, {47'd0, e});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (src_en) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i] && srcq[i].size() > 0) e = srcq[i].pop_front();
            end
            drive();
        end
        #1;
    endtask

    task automatic run_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drained"}, sbq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int err0;
        int viol;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        vecs[0] = '{4'b0001, 4'b0000, 1'b0, 16'h1234, 4'b0001, 1'b1, 17'h01234};
        vecs[1] = '{4'b0001, 4'b0000, 1'b1, 16'h1234, 4'b0000, 1'b0, 17'h01234};
        vecs[2] = '{4'b0000, 4'b0000, 1'b0, 16'h5555, 4'b0001, 1'b0, 17'h05555};
        vecs[3] = '{4'b1110, 4'b0001, 1'b0, 16'hBEEF, 4'b0001, 1'b0, 17'h1BEEF};
        vecs[4] = '{4'b1111, 4'b1111, 1'b1, 16'h0F0F, 4'b0000, 1'b0, 17'h10F0F};
        vecs[5] = '{4'b0001, 4'b1110, 1'b0, 16'h6789, 4'b0001, 1'b1, 17'h06789};
        vecs[6] = '{4'b1110, 4'b0000, 1'b1, 16'hAAAA, 4'b0000, 1'b0, 17'h0AAAA};
        vecs[7] = '{4'b0001, 4'b0001, 1'b0, 16'hCAFE, 4'b0001, 1'b1, 17'h1CAFE};

        // reset values
        @(posedge clk);
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_write", fifo_write, 0);
        chk("rst_err", err_tmo, 0);
        chk("rst_data", fifo_data_in, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // single packet from requester 2
        srcq[2].push_back(17'h00011); srcq[2].push_back(17'h00022); srcq[2].push_back(17'h10033);
        sbq.push_back(17'h00011);     sbq.push_back(17'h00022);     sbq.push_back(17'h10033);
        drive();
        step();
        chk("single_grant", grant, 4'b0100);
        chk("single_ready", req_ready, 4'b0100);
        chk("single_write1", fifo_write, 1);
        chk("single_data1", fifo_data_in, 17'h00011);
        step();
        chk("single_data2", fifo_data_in, 17'h00022);
        step();
        chk("single_data3", fifo_data_in, 17'h10033);
        step();
        chk("single_idle_grant", grant, 0);
        chk("single_idle_write", fifo_write, 0);
        chk("single_grant_id", grant_id, 2);
        chk("single_drained", sbq.size(), 0);

        // packet lock: requester 0 four beats while requester 1 waits (ptr=3)
        gseq.delete(); wcyc.delete();
        for (int k = 0; k < 4; k++) begin
            srcq[0].push_back({(k == 3), 16'h00A0 + W'(k)});
            sbq.push_back({(k == 3), 16'h00A0 + W'(k)});
        end
        srcq[1].push_back(17'h100B0);
        sbq.push_back(17'h100B0);
        drive();
        run_drain("lock", 30);
        chk("lock_ngrants", gseq.size(), 2);
        chk("lock_nwrites", wcyc.size(), 5);
        if (gseq.size() == 2) begin
            chk("lock_first", gseq[0], 0);
            chk("lock_second", gseq[1], 1);
        end
        if (wcyc.size() == 5) begin
            chk("lock_contig", wcyc[3] - wcyc[0], 3);
            chk("lock_bubble", wcyc[4] - wcyc[3], 2);
        end

        // back-pressure for 100 cycles mid-packet (ptr=2, only requester 1 valid)
        err0 = n_err;
        srcq[1].push_back(17'h000C0); srcq[1].push_back(17'h000C1); srcq[1].push_back(17'h100C2);
        sbq.push_back(17'h000C0);     sbq.push_back(17'h000C1);     sbq.push_back(17'h100C2);
        drive();
        step();
        chk("bp_grant", grant, 4'b0010);
        step();
        fifo_full = 1'b1;
        #1;
        chk("bp_ready_comb", req_ready, 0);
        chk("bp_write_comb", fifo_write, 0);
        viol = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (req_ready != '0 || fifo_write || err_tmo || grant != 4'b0010) viol++;
        end
        chk("bp_stalled", viol, 0);
        fifo_full = 1'b0;
        run_drain("bp", 10);
        chk("bp_no_tmo", n_err - err0, 0);

        // table-driven combinational checks with requester 0 locked (ptr=2)
        src_en = 1'b0;
        sb_en  = 1'b0;
        req_valid = 4'b0001;
        req_last  = '0;
        req_data  = {16'hD003, 16'hD002, 16'hD001, 16'h1234};
        step();
        chk("tbl_grant0", grant, 4'b0001);
        for (int v = 0; v < 8; v++) begin
            req_valid      = vecs[v].valid;
            req_last       = vecs[v].last;
            fifo_full      = vecs[v].full;
            req_data[W-1:0] = vecs[v].d0;
            #1;
            chk($sformatf("tbl%0d_ready", v), req_ready, vecs[v].exp_ready);
            chk($sformatf("tbl%0d_write", v), fifo_write, vecs[v].exp_write);
            chk($sformatf("tbl%0d_data", v), fifo_data_in, vecs[v].exp_data);
            chk($sformatf("tbl%0d_grant", v), grant, 4'b0001);
            step();
        end
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        #1;
        chk("tbl_end_idle", grant, 0);
        src_en = 1'b1;
        sb_en  = 1'b1;

        // timeout: requester 3 goes silent mid-packet, requester 0 pending (ptr=1)
        err0 = n_err;
        srcq[3].push_back(17'h03333);
        srcq[0].push_back(17'h10F0F);
        sbq.push_back(17'h03333);
        sbq.push_back(17'h10F0F);
        drive();
        step();
        chk("tmo_grant3", grant, 4'b1000);
        step();
        viol = 0;
        for (int k = 0; k < TMO - 1; k++) begin
            step();
            if (err_tmo || grant != 4'b1000) viol++;
        end
        chk("tmo_not_early", viol, 0);
        step();
        chk("tmo_err", err_tmo, 1);
        chk("tmo_grant_cleared", grant, 0);
        step();
        chk("tmo_err_one_cycle", err_tmo, 0);
        chk("tmo_next_grant", grant, 4'b0001);
        run_drain("tmo", 10);
        chk("tmo_err_count", n_err - err0, 1);

        // asynchronous reset in the middle of a packet (ptr=1)
        srcq[2].push_back(17'h00101); srcq[2].push_back(17'h00202); srcq[2].push_back(17'h10303);
        sbq.push_back(17'h00101);
        drive();
        step();
        chk("arst_grant", grant, 4'b0100);
        step();
        #1;
        rst = 1'b0;
        #1;
        chk("arst_grant0", grant, 0);
        chk("arst_grant_id0", grant_id, 0);
        chk("arst_ready0", req_ready, 0);
        chk("arst_write0", fifo_write, 0);
        chk("arst_data0", fifo_data_in, 0);
        chk("arst_err0", err_tmo, 0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        sbq.delete();
        drive();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        gseq.delete();
        srcq[1].push_back(17'h11111);
        srcq[3].push_back(17'h13333);
        sbq.push_back(17'h11111);
        sbq.push_back(17'h13333);
        drive();
        run_drain("arst", 20);
        chk("arst_ngrants", gseq.size(), 2);
        if (gseq.size() > 0) chk("arst_first_grant", gseq[0], 1);

        // round-robin: every requester has two 1-beat packets queued (ptr=0)
        gseq.delete(); wcyc.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                srcq[i].push_back({1'b1, W'(16'h0100 * i + k)});
                sbq.push_back({1'b1, W'(16'h0100 * i + k)});
            end
        end
        drive();
        run_drain("rr", 40);
        chk("rr_ngrants", gseq.size(), 8);
        if (gseq.size() == 8) begin
            for (int j = 0; j < 8; j++) chk($sformatf("rr_order%0d", j), gseq[j], j % N);
        end
        viol = 0;
        for (int j = 1; j < wcyc.size(); j++) begin
            if (wcyc[j] - wcyc[j-1] != 2) viol++;
        end
        chk("rr_nwrites", wcyc.size(), 8);
        chk("rr_spacing", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
